axi_simple_master: RTL and testbench
====================================

AXI_SIMPLE_MASTER -- requirements
Module: axi_simple_master

Interface
REQ-001 SHALL have parameter: AXI_ID, 0, value driven on arid/awid and expected on rid/bid.
REQ-002 SHALL have parameter: ADDR_W, 32, width of req_addr.
REQ-003 SHALL have port: clk  input  1  clock, all logic on posedge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req_valid  input  1  request present.
REQ-006 SHALL have port: req_ready  output  1  request accepted this cycle.
REQ-007 SHALL have port: req_we  input  1  1=write, 0=read.
REQ-008 SHALL have port: req_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port: req_wdata  input  32  write data.
REQ-010 SHALL have port: req_wstrb  input  4  write byte strobes.
REQ-011 SHALL have port: rsp_valid  output  1  response present.
REQ-012 SHALL have port: rsp_ready  input  1  response consumed.
REQ-013 SHALL have port: rsp_rdata  output  32  read data (0 for writes).
REQ-014 SHALL have port: rsp_err  output  1  error response.
REQ-015 SHALL have port: axi_mosi  output  s_axi_mosi_t  AXI manager outputs.
REQ-016 SHALL have port: axi_miso  input  s_axi_miso_t  AXI subordinate responses.

Function
REQ-017 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP; one outstanding transaction max.
REQ-018 SHALL assert req_ready only in IDLE; handshake req_valid&req_ready captures req_we/addr/wdata/wstrb into registers.
REQ-019 SHALL go IDLE->RD_ADDR on accepted read, IDLE->WR_REQ on accepted write.
REQ-020 SHALL in RD_ADDR drive arvalid=1, araddr=captured addr, arid=AXI_ID, arlen=0, arsize=3'b010, arburst=INCR; on arready go RD_DATA next cycle.
REQ-021 SHALL keep all AW/AR/W payload stable while the corresponding valid is high and unacknowledged.
REQ-022 SHALL in RD_DATA drive rready=1; on rvalid capture rdata, set err=(rresp!=OKAY)|(rid!=AXI_ID)|~rlast, go RSP.
REQ-023 SHALL in WR_REQ assert awvalid and wvalid together (wlast=1, awlen=0, awsize=3'b010), drop each independently on its own ready; go WR_RESP once both handshakes done (same or different cycles).
REQ-024 SHALL in WR_RESP drive bready=1; on bvalid set err=(bresp!=OKAY)|(bid!=AXI_ID), rdata=0, go RSP.
REQ-025 SHALL in RSP drive rsp_valid=1 with stable rsp_rdata/rsp_err; on rsp_ready go IDLE; req_ready=0 throughout RSP.
REQ-026 SHALL assert rready/bready only in RD_DATA/WR_RESP; r/b beats arriving elsewhere are not consumed.
REQ-027 SHALL tie all unused AXI mosi fields (user, lock, cache, prot, qos, region) to 0.
REQ-028 SHALL accept a new request at the earliest one cycle after rsp handshake (IDLE re-entry).

Reset
REQ-029 SHALL on rst=1 return FSM to IDLE next edge, regardless of state (mid-transaction abandon allowed).
REQ-030 SHALL hold after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, arvalid=awvalid=wvalid=rready=bready=0.

Structure
REQ-031 SHALL use s_axi_mosi_t, s_axi_miso_t, axi_error_t from amba_axi_pkg; FSM state enum local to module.
REQ-032 SHALL be a single module, no sub-modules; a boot_rom-backed AXI ROM slave serves as bench target.

Verification
REQ-033 SHALL cover read: addr 0x0000_0010, slave rdata 0xDEADBEEF OKAY after 2 wait cycles -> rsp_valid with rdata 0xDEADBEEF, err=0.
REQ-034 SHALL cover write: addr 0x40, wdata 0x12345678, wstrb 0xF; awready 3 cycles before wready -> awvalid drops first, one bresp OKAY -> rsp err=0, rdata=0.
REQ-035 SHALL cover error: read returning rresp SLVERR -> rsp_err=1; write bresp DECERR -> rsp_err=1.
REQ-036 SHALL cover backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, req_ready=0, no new AR issued.
REQ-037 SHALL cover reset mid RD_DATA -> next cycle all valids/readies 0, req_ready=1.
REQ-038 SHALL cover back-to-back: 4 reads to 0x0,0x4,0x8,0xC with rsp_ready=1 -> 4 in-order responses, one AR per request.

Source files
------------

// File: rtl/amba_axi_pkg.sv
// AXI4 channel bundles and response codes shared by the single-beat 32-bit managers.
package amba_axi_pkg;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_error_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]     awid;
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic [7:0]              awlen;
        logic [2:0]              awsize;
        logic [1:0]              awburst;
        logic                    awlock;
        logic [3:0]              awcache;
        logic [2:0]              awprot;
        logic [3:0]              awqos;
        logic [3:0]              awregion;
        logic                    awuser;
        logic                    awvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
        logic                    wuser;
        logic                    wvalid;
        logic                    bready;
        logic [AXI_ID_W-1:0]     arid;
        logic [AXI_ADDR_W-1:0]   araddr;
        logic [7:0]              arlen;
        logic [2:0]              arsize;
        logic [1:0]              arburst;
        logic                    arlock;
        logic [3:0]              arcache;
        logic [2:0]              arprot;
        logic [3:0]              arqos;
        logic [3:0]              arregion;
        logic                    aruser;
        logic                    arvalid;
        logic                    rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                    awready;
        logic                    wready;
        logic [AXI_ID_W-1:0]     bid;
        axi_error_t              bresp;
        logic                    bvalid;
        logic                    arready;
        logic [AXI_ID_W-1:0]     rid;
        logic [AXI_DATA_W-1:0]   rdata;
        axi_error_t              rresp;
        logic                    rlast;
        logic                    rvalid;
    } s_axi_miso_t;
endpackage

// File: rtl/axi_simple_master.sv
// Converts a simple valid/ready request/response port into single-beat AXI4
// transactions, one outstanding at a time.
module axi_simple_master
    import amba_axi_pkg::*;
#(
    parameter int AXI_ID = 0,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output s_axi_mosi_t       axi_mosi,
    input  s_axi_miso_t       axi_miso
);
    // Handshake rule on every port: a transfer happens on the rising edge where
    // valid and ready are both high; valid never waits on ready.
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

    localparam logic [AXI_ID_W-1:0] ID_VAL = AXI_ID_W'(AXI_ID);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              aw_hs, w_hs;

    assign aw_hs = axi_mosi.awvalid && axi_miso.awready;
    assign w_hs  = axi_mosi.wvalid && axi_miso.wready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        axi_mosi  = '0;
        // Payload is driven from the capture registers at all times so it cannot
        // move while a valid is waiting for its ready.
        axi_mosi.awid    = ID_VAL;
        axi_mosi.awaddr  = AXI_ADDR_W'(addr_q);
        axi_mosi.awsize  = AXI_SIZE_4B;
        axi_mosi.awburst = AXI_BURST_INCR;
        axi_mosi.wdata   = wdata_q;
        axi_mosi.wstrb   = wstrb_q;
        axi_mosi.wlast   = 1'b1;
        axi_mosi.arid    = ID_VAL;
        axi_mosi.araddr  = AXI_ADDR_W'(addr_q);
        axi_mosi.arsize  = AXI_SIZE_4B;
        axi_mosi.arburst = AXI_BURST_INCR;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_we ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                axi_mosi.arvalid = 1'b1;
                if (axi_miso.arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                axi_mosi.rready = 1'b1;
                if (axi_miso.rvalid) state_nxt = RSP;
            end
            WR_REQ: begin
                axi_mosi.awvalid = !aw_done;
                axi_mosi.wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                axi_mosi.bready = 1'b1;
                if (axi_miso.bvalid) state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_REQ && aw_hs) aw_done <= 1'b1;
            if (state == WR_REQ && w_hs)  w_done  <= 1'b1;
            if (state == RD_DATA && axi_miso.rvalid) begin
                rdata_q <= axi_miso.rdata;
                err_q   <= (axi_miso.rresp != OKAY) || (axi_miso.rid != ID_VAL) || !axi_miso.rlast;
            end
            if (state == WR_RESP && axi_miso.bvalid) begin
                rdata_q <= '0;
                err_q   <= (axi_miso.bresp != OKAY) || (axi_miso.bid != ID_VAL);
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_axi_simple_master.sv
// Bench for axi_simple_master: ROM-backed AXI slave model, request driver,
// response scoreboard, directed and randomized transactions.
`timescale 1ns/1ps
module tb_axi_simple_master;
  import amba_axi_pkg::*;

  localparam logic [3:0] TB_ID = 4'd2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  axi_simple_master #(.AXI_ID(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .axi_mosi(axi_mosi), .axi_miso(axi_miso)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [32:0] exp_q[$];     // {err, rdata}
  logic [31:0] ar_exp_q[$];  // expected araddr
  logic [67:0] wr_exp_q[$];  // {awaddr, wdata, wstrb}

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- slave configuration / ROM ----------------
  logic [31:0] rom [16];
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  axi_error_t rresp_cfg = OKAY;
  axi_error_t bresp_cfg = OKAY;
  logic rid_bad = 1'b0;
  logic rlast_bad = 1'b0;
  int ar_count = 0, aw_count = 0, w_count = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0;
  int aw_rehold = 0, w_rehold = 0;

  initial begin : slave_model
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_s;
    logic rd_pend, aw_got, w_got, b_pend, ar_seen, aw_seen;
    int ar_cnt, aw_cnt, w_cnt, rd_cnt, b_cnt;
    logic [31:0] rd_addr, ar_first, aw_first, wa, wd;
    logic [3:0] ws;
    logic [16:0] ar_attr, aw_attr;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; ar_seen = 0; aw_seen = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; rd_cnt = 0; b_cnt = 0;
    rd_addr = 0; ar_first = 0; aw_first = 0; wa = 0; wd = 0; ws = 0;
    ar_attr = 0; aw_attr = 0;
    axi_miso = '0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      ar_hs = axi_mosi.arvalid & axi_miso.arready;
      r_hs  = axi_miso.rvalid & axi_mosi.rready;
      aw_hs = axi_mosi.awvalid & axi_miso.awready;
      w_hs  = axi_mosi.wvalid & axi_miso.wready;
      b_hs  = axi_miso.bvalid & axi_mosi.bready;
      if (axi_mosi.arvalid && !ar_seen) begin ar_first = axi_mosi.araddr; ar_seen = 1; end
      if (axi_mosi.awvalid && !aw_seen) begin aw_first = axi_mosi.awaddr; aw_seen = 1; end
      if (ar_hs) begin
        rd_addr = axi_mosi.araddr;
        ar_attr = {axi_mosi.arid, axi_mosi.arlen, axi_mosi.arsize, axi_mosi.arburst};
      end
      if (aw_hs) begin
        wa = axi_mosi.awaddr;
        aw_attr = {axi_mosi.awid, axi_mosi.awlen, axi_mosi.awsize, axi_mosi.awburst};
      end
      if (w_hs) begin wd = axi_mosi.wdata; ws = axi_mosi.wstrb; end
      if (!rst && aw_got && axi_mosi.awvalid) aw_rehold++;
      if (!rst && w_got && axi_mosi.wvalid) w_rehold++;
      @(posedge clk); #1;
      if (rst_s) begin
        axi_miso = '0;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; ar_seen = 0; aw_seen = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      // read address / data
      if (ar_hs) begin
        ar_count++;
        axi_miso.arready = 0; ar_seen = 0; ar_cnt = 0;
        chk("ar_stable", rd_addr, ar_first);
        chk("ar_attr", ar_attr, {TB_ID, 8'd0, 3'b010, 2'b01});
        chk("ar_expected", ar_exp_q.size() != 0, 1);
        if (ar_exp_q.size() != 0) chk("araddr", rd_addr, ar_exp_q.pop_front());
        rd_pend = 1; rd_cnt = r_wait;
      end
      if (r_hs) begin axi_miso.rvalid = 0; axi_miso.rlast = 0; rd_pend = 0; end
      if (!rd_pend && axi_mosi.arvalid && !axi_miso.arready) begin
        if (ar_cnt >= ar_wait) axi_miso.arready = 1;
        else ar_cnt++;
      end
      if (rd_pend && !axi_miso.rvalid) begin
        if (rd_cnt == 0) begin
          axi_miso.rvalid = 1;
          axi_miso.rdata  = rom[rd_addr[5:2]];
          axi_miso.rresp  = rresp_cfg;
          axi_miso.rid    = rid_bad ? (TB_ID ^ 4'd1) : TB_ID;
          axi_miso.rlast  = !rlast_bad;
        end else rd_cnt--;
      end
      // write address / data / response
      if (aw_hs) begin
        aw_count++; aw_hs_cyc = cyc;
        axi_miso.awready = 0; aw_got = 1; aw_seen = 0; aw_cnt = 0;
        chk("aw_stable", wa, aw_first);
        chk("aw_attr", aw_attr, {TB_ID, 8'd0, 3'b010, 2'b01});
      end
      if (w_hs) begin
        w_count++; w_hs_cyc = cyc;
        axi_miso.wready = 0; w_got = 1; w_cnt = 0;
      end
      if (aw_got && w_got && !b_pend && (aw_hs || w_hs)) begin
        chk("wr_expected", wr_exp_q.size() != 0, 1);
        if (wr_exp_q.size() != 0) chk("wr_payload", {wa, wd, ws}, wr_exp_q.pop_front());
        b_pend = 1; b_cnt = b_wait;
      end
      if (b_hs) begin axi_miso.bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0; end
      if (!aw_got && axi_mosi.awvalid && !axi_miso.awready) begin
        if (aw_cnt >= aw_wait) axi_miso.awready = 1;
        else aw_cnt++;
      end
      if (!w_got && axi_mosi.wvalid && !axi_miso.wready) begin
        if (w_cnt >= w_wait) axi_miso.wready = 1;
        else w_cnt++;
      end
      if (b_pend && !axi_miso.bvalid && !b_hs) begin
        if (b_cnt == 0) begin
          axi_miso.bvalid = 1;
          axi_miso.bresp  = bresp_cfg;
          axi_miso.bid    = TB_ID;
        end else b_cnt--;
      end
    end
  end

  // ---------------- response consumer ----------------
  int rsp_mode = 1;  // 0 hold low, 1 always ready, 2 random
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_mode == 0) rsp_ready = 1'b0;
      else if (rsp_mode == 1) rsp_ready = 1'b1;
      else rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic [32:0] mon_e;
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
        chk("rsp_err", rsp_err, mon_e[32]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    int n;
    logic [31:0] word;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 300) break;
    end
    chk("req_accept_timeout", req_ready, 1);
    // Reference model: reads return the ROM word (error flag from the configured
    // response), writes return zero data with the configured write response.
    word = rom[addr[5:2]];
    if (we) begin
      exp_q.push_back({bresp_cfg != OKAY, 32'd0});
      wr_exp_q.push_back({addr, wdata, wstrb});
    end else begin
      exp_q.push_back({(rresp_cfg != OKAY) || rid_bad || rlast_bad, word});
      ar_exp_q.push_back(addr);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    chk("rsp_timeout", exp_q.size(), 0);
  endtask

  task automatic set_slave(input int arw, input int rw, input int aww, input int ww, input int bw);
    ar_wait = arw; r_wait = rw; aw_wait = aww; w_wait = ww; b_wait = bw;
    rresp_cfg = OKAY; bresp_cfg = OKAY; rid_bad = 0; rlast_bad = 0;
  endtask

  // ---------------- main sequence ----------------
  int ar_before, n, k;
  logic rw;
  logic [31:0] ra;

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    for (int i = 0; i < 16; i++) rom[i] = $urandom();
    rom[4] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_axi_valids", {axi_mosi.arvalid, axi_mosi.awvalid, axi_mosi.wvalid,
                           axi_mosi.rready, axi_mosi.bready}, 0);
    chk("tie_zero", {axi_mosi.awlock, axi_mosi.awcache, axi_mosi.awprot, axi_mosi.awqos,
                     axi_mosi.awregion, axi_mosi.awuser, axi_mosi.arlock, axi_mosi.arcache,
                     axi_mosi.arprot, axi_mosi.arqos, axi_mosi.arregion, axi_mosi.aruser,
                     axi_mosi.wuser}, 0);

    // read with two wait cycles on R
    set_slave(0, 2, 0, 0, 0);
    issue(0, 32'h0000_0010, 0, 0);
    wait_done();

    // write: AW accepted three cycles before W
    set_slave(0, 0, 0, 3, 1);
    issue(1, 32'h40, 32'h1234_5678, 4'hF);
    wait_done();
    chk("aw_before_w_gap", w_hs_cyc - aw_hs_cyc, 3);

    // error responses
    set_slave(0, 0, 0, 0, 0);
    rresp_cfg = SLVERR;
    issue(0, 32'h4, 0, 0);
    wait_done();
    set_slave(0, 0, 0, 0, 0);
    bresp_cfg = DECERR;
    issue(1, 32'h8, 32'hA5A5_0F0F, 4'h3);
    wait_done();
    set_slave(1, 1, 0, 0, 0);
    rid_bad = 1;
    issue(0, 32'h18, 0, 0);
    wait_done();
    set_slave(0, 0, 0, 0, 0);
    rlast_bad = 1;
    issue(0, 32'h1C, 0, 0);
    wait_done();

    // response backpressure with a competing request waiting
    set_slave(0, 1, 0, 0, 0);
    rsp_mode = 0;
    issue(0, 32'h8, 0, 0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_rsp_seen", rsp_valid, 1);
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_addr = 32'hC;
    ar_before = ar_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, rom[2]);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_no_new_ar", ar_count - ar_before, 0);
    end
    @(posedge clk); #1;
    req_valid = 0; rsp_mode = 1;
    wait_done();

    // reset while waiting in RD_DATA
    set_slave(0, 40, 0, 0, 0);
    issue(0, 32'h14, 0, 0);
    n = 0;
    while (!axi_mosi.rready && n < 100) begin @(negedge clk); n++; end
    chk("mid_rd_data_reached", axi_mosi.rready, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_axi", {axi_mosi.arvalid, axi_mosi.awvalid, axi_mosi.wvalid,
                        axi_mosi.rready, axi_mosi.bready}, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    exp_q.delete(); ar_exp_q.delete(); wr_exp_q.delete();
    @(posedge clk); #1;
    rst = 0;

    // back-to-back reads
    set_slave(0, 0, 0, 0, 0);
    ar_before = ar_count;
    issue(0, 32'h0, 0, 0);
    issue(0, 32'h4, 0, 0);
    issue(0, 32'h8, 0, 0);
    issue(0, 32'hC, 0, 0);
    wait_done();
    chk("b2b_ar_count", ar_count - ar_before, 4);

    // randomized traffic with random response backpressure
    rsp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      k = $urandom_range(0, 7);
      rresp_cfg = (k == 0) ? SLVERR : (k == 1) ? DECERR : OKAY;
      k = $urandom_range(0, 7);
      bresp_cfg = (k == 0) ? SLVERR : (k == 1) ? EXOKAY : OKAY;
      rid_bad = ($urandom_range(0, 15) == 0);
      rlast_bad = ($urandom_range(0, 15) == 0);
      rw = 1'($urandom_range(0, 1));
      ra = 32'($urandom_range(0, 15)) << 2;
      issue(rw, ra, $urandom(), 4'($urandom_range(1, 15)));
      wait_done();
    end
    rsp_mode = 1;
    repeat (3) @(negedge clk);

    chk("aw_no_reassert", aw_rehold, 0);
    chk("w_no_reassert", w_rehold, 0);
    chk("aw_w_balance", aw_count - w_count, 0);
    chk("ar_q_drained", ar_exp_q.size(), 0);
    chk("wr_q_drained", wr_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
